// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator producing syncs, blanking,
// scaled coordinates, pipeline-advance strobes and a frame counter.
//   clkPixel        pixel-domain clock
//   reset           asynchronous active-high reset
//   pixelEn         clock enable; counters and registers advance only when 1
//   hsync, vsync    registered syncs with configurable asserted level
//   videoActive     inside the visible window
//   lineStarting    strobe PIPELINE_DELAY+1 pixels before line start
//   lineEnding      strobe PIPELINE_DELAY+1 pixels before the visible region ends
//   hsyncStarting   strobe PIPELINE_DELAY+1 pixels before hsync asserts
//   frameStarting   strobe on the last pixel of the frame
//   hPos, vPos      scaled coordinates, 0 outside the visible region
//   nextFrameActive next line is visible
//   nextVPos        scaled coordinate of the next line, 0 if not visible
//   frameCount      frames completed, wraps 255 -> 0
module video_timing_gen #(
   parameter int H_VISIBLE      = 320,
   parameter int H_FRONT        = 8,
   parameter int H_SYNC         = 48,
   parameter int H_BACK         = 24,
   parameter int H_SYNC_POL     = 0,
   parameter int V_VISIBLE      = 480,
   parameter int V_FRONT        = 10,
   parameter int V_SYNC         = 2,
   parameter int V_BACK         = 33,
   parameter int V_SYNC_POL     = 0,
   parameter int H_SCALE_SHIFT  = 0,
   parameter int V_SCALE_SHIFT  = 1,
   parameter int PIPELINE_DELAY = 0,
   parameter int COORD_W        = 11
) (
   input  logic               clkPixel,
   input  logic               reset,
   input  logic               pixelEn,
   output logic               hsync,
   output logic               vsync,
   output logic               videoActive,
   output logic               lineStarting,
   output logic               lineEnding,
   output logic               hsyncStarting,
   output logic               frameStarting,
   output logic [COORD_W-1:0] hPos,
   output logic [COORD_W-1:0] vPos,
   output logic               nextFrameActive,
   output logic [COORD_W-1:0] nextVPos,
   output logic [7:0]         frameCount
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (PIPELINE_DELAY < 0 || PIPELINE_DELAY > H_VISIBLE - 1 ||
       ((H_TOTAL - 1) >> COORD_W) != 0 || ((V_TOTAL - 1) >> COORD_W) != 0) begin : gBadParams
      $error("video_timing_gen: illegal PIPELINE_DELAY or COORD_W too narrow");
   end

   localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS      = COORD_W'(H_VISIBLE);
   localparam logic [COORD_W-1:0] H_VIS_LAST = COORD_W'(H_VISIBLE - 1);
   localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_VISIBLE + H_FRONT);
   localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_VIS      = COORD_W'(V_VISIBLE);
   localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_VISIBLE + V_FRONT);
   localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [COORD_W-1:0] LS_AT      = COORD_W'(H_TOTAL - 1 - PIPELINE_DELAY);
   localparam logic [COORD_W-1:0] LE_AT      = COORD_W'(H_VISIBLE - 1 - PIPELINE_DELAY);
   localparam logic [COORD_W-1:0] HSS_AT     = COORD_W'(H_VISIBLE + H_FRONT - 1 - PIPELINE_DELAY);
   localparam logic               HPOL       = H_SYNC_POL != 0;
   localparam logic               VPOL       = V_SYNC_POL != 0;

   logic [COORD_W-1:0] hCount, vCount, nextVCount, hNext;
   logic               strobeEn;

   always_comb begin
      hNext           = hCount == H_LAST ? '0 : hCount + COORD_W'(1);
      strobeEn        = pixelEn && !reset;
      videoActive     = hCount < H_VIS && vCount < V_VIS;
      hPos            = hCount < H_VIS ? hCount >> H_SCALE_SHIFT : '0;
      vPos            = vCount < V_VIS ? vCount >> V_SCALE_SHIFT : '0;
      nextFrameActive = nextVCount < V_VIS;
      nextVPos        = nextFrameActive ? nextVCount >> V_SCALE_SHIFT : '0;
      lineStarting    = strobeEn && hCount == LS_AT;
      lineEnding      = strobeEn && hCount == LE_AT;
      hsyncStarting   = strobeEn && hCount == HSS_AT;
      frameStarting   = strobeEn && hCount == H_LAST && vCount == V_LAST;
   end

   // hsync is computed from hNext so the registered value lines up with hCount;
   // vsync follows the line that vCount is about to load.
   always_ff @(posedge clkPixel or posedge reset) begin
      if (reset) begin
         hCount     <= '0;
         vCount     <= '0;
         nextVCount <= '0;
         frameCount <= '0;
         hsync      <= ~HPOL;
         vsync      <= ~VPOL;
      end else if (pixelEn) begin
         hCount <= hNext;
         hsync  <= hNext >= HS_FIRST && hNext <= HS_LAST ? HPOL : ~HPOL;
         if (hCount == H_VIS_LAST)
            nextVCount <= vCount == V_LAST ? '0 : vCount + COORD_W'(1);
         if (hCount == H_LAST) begin
            vCount <= nextVCount;
            vsync  <= nextVCount >= VS_FIRST && nextVCount <= VS_LAST ? VPOL : ~VPOL;
         end
         if (frameStarting)
            frameCount <= frameCount + 8'd1;
      end
   end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: self-checking bench for video_timing_gen on a reduced raster.
module tb_video_timing_gen;
   localparam int HV = 12, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
   localparam int VV = 8, VF = 2, VS = 2, VB = 2, VT = VV + VF + VS + VB;
   localparam int HSH = 1, VSH = 1, PD = 2, CW = 8, FT = HT * VT;
   localparam logic HP = 1'b0, VP = 1'b1;

   logic          clkPixel = 0, reset = 1, pixelEn = 0;
   logic          hsync, vsync, videoActive, lineStarting, lineEnding, hsyncStarting, frameStarting;
   logic          nextFrameActive;
   logic [CW-1:0] hPos, vPos, nextVPos;
   logic [7:0]    frameCount;
   int            n = 0, checks = 0, errors = 0;
   int            mh, mv, mnv;
   logic          men;

   video_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_SYNC_POL(0),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_SYNC_POL(1),
      .H_SCALE_SHIFT(HSH), .V_SCALE_SHIFT(VSH), .PIPELINE_DELAY(PD), .COORD_W(CW)
   ) dut (
      .clkPixel(clkPixel), .reset(reset), .pixelEn(pixelEn), .hsync(hsync), .vsync(vsync),
      .videoActive(videoActive), .lineStarting(lineStarting), .lineEnding(lineEnding),
      .hsyncStarting(hsyncStarting), .frameStarting(frameStarting), .hPos(hPos), .vPos(vPos),
      .nextFrameActive(nextFrameActive), .nextVPos(nextVPos), .frameCount(frameCount)
   );

   always #5 clkPixel = ~clkPixel;

   // Model state: n is the number of enabled pixels since reset; everything else is
   // derived from it arithmetically.
   always @(posedge clkPixel or posedge reset)
      if (reset) n = 0;
      else if (pixelEn) n = n + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clkPixel) begin
      mh  = n % HT;
      mv  = (n / HT) % VT;
      mnv = mh >= HV ? (mv + 1) % VT : mv;
      men = pixelEn && !reset;
      chk("hsync", hsync, (mh >= HV + HF && mh < HV + HF + HS) ? HP : !HP);
      chk("vsync", vsync, (mv >= VV + VF && mv < VV + VF + VS) ? VP : !VP);
      chk("videoActive", videoActive, mh < HV && mv < VV);
      chk("hPos", hPos, mh < HV ? mh >> HSH : 0);
      chk("vPos", vPos, mv < VV ? mv >> VSH : 0);
      chk("nextFrameActive", nextFrameActive, mnv < VV);
      chk("nextVPos", nextVPos, mnv < VV ? mnv >> VSH : 0);
      chk("lineStarting", lineStarting, men && mh == HT - 1 - PD);
      chk("lineEnding", lineEnding, men && mh == HV - 1 - PD);
      chk("hsyncStarting", hsyncStarting, men && mh == HV + HF - 1 - PD);
      chk("frameStarting", frameStarting, men && mh == HT - 1 && mv == VT - 1);
      chk("frameCount", frameCount, (n / FT) % 256);
   end

   task automatic goto(input int th, input int tv);
      logic found = 0;
      for (int k = 0; k < 2 * FT && !found; k++) begin
         @(negedge clkPixel);
         found = (n % HT == th) && ((n / HT) % VT == tv);
      end
      chk("goto_reached", found, 1);
   endtask

   task automatic waitFs(output int c);
      c = 0;
      do begin
         @(negedge clkPixel);
         c++;
      end while (!frameStarting && c < 4 * FT);
      chk("frameStarting_seen", frameStarting, 1);
   endtask

   initial begin
      int cnt, seen, first, per, fs;
      repeat (3) @(negedge clkPixel);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 0);
      chk("rst_frameCount", frameCount, 0);
      chk("rst_lineStarting", lineStarting, 0);
      #1 reset = 0; pixelEn = 1;
      goto(11, 5);
      chk("pin_hPos319", hPos, 5);
      chk("pin_vPos", vPos, 2);
      chk("pin_active", videoActive, 1);
      chk("pin_hsyncStarting", hsyncStarting, 1);
      @(negedge clkPixel);
      chk("pin_hPos_blank", hPos, 0);
      chk("pin_active_blank", videoActive, 0);
      chk("pin_nextVPos", nextVPos, 3);
      chk("pin_nextActive", nextFrameActive, 1);
      goto(9, 7);
      chk("pin_lineEnding", lineEnding, 1);
      goto(12, 7);
      chk("pin_nextActive_last", nextFrameActive, 0);
      chk("pin_nextVPos_last", nextVPos, 0);
      goto(17, 7);
      chk("pin_lineStarting", lineStarting, 1);
      goto(0, 10);
      chk("pin_vsync_on", vsync, 1);
      goto(0, 12);
      chk("pin_vsync_off", vsync, 0);
      goto(0, 13);
      cnt = 0;
      repeat (HT) begin
         if (!hsync) cnt++;
         @(negedge clkPixel);
      end
      chk("hsync_width", cnt, HS);
      waitFs(per);
      waitFs(per);
      chk("frame_period", per, FT);
      seen = 0; first = 0; per = 0;
      for (int c = 0; c < 4 * FT && seen < 2; c++) begin
         @(negedge clkPixel);
         if (frameStarting) begin
            if (seen == 1) per = c - first;
            first = c;
            seen++;
         end
         #1 pixelEn = ~pixelEn;
      end
      chk("toggle_frame_period", per, 2 * FT);
      pixelEn = 1;
      goto(15, 3);
      chk("pre_reset_hsync", hsync, 0);
      #2 reset = 1;
      #1;
      chk("async_hsync", hsync, 1);
      chk("async_frameCount", frameCount, 0);
      chk("async_vPos", vPos, 0);
      chk("async_active", videoActive, 1);
      @(negedge clkPixel);
      #1 reset = 0;
      #1;
      chk("release_hPos", hPos, 0);
      chk("release_vPos", vPos, 0);
      chk("release_active", videoActive, 1);
      chk("release_frameCount", frameCount, 0);
      fs = 0;
      for (int c = 0; c < 257 * FT && fs < 256; c++) begin
         @(negedge clkPixel);
         if (frameStarting) fs++;
      end
      chk("frames_seen", fs, 256);
      chk("frameCount_255", frameCount, 255);
      @(negedge clkPixel);
      chk("frameCount_wrap", frameCount, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
